// File: rtl/key_word_router.sv
// Serial key-entry word assembler that routes each word by its MSBs into per-channel circular buffers.
// Optional build macro KEY_TIMEOUT_EN aborts a partial word after TIMEOUT idle cycles.

module key_word_router_ch #(
  parameter int DEPTH     = 6,
  parameter int DATA_W    = 2,
  parameter int OVERWRITE = 1,
  parameter int CW        = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_i,
  input  logic [DATA_W-1:0]             wdata_i,
  input  logic                          pop_i,
  output logic [DATA_W-1:0]             head_o,
  output logic [CW-1:0]                 cnt_o,
  output logic                          full_o,
  output logic                          ovf_o,
  output logic [DEPTH*(DATA_W+1)-1:0]   slots_o
);
  localparam int ENT_W = DATA_W + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam bit OVW = (OVERWRITE != 0);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic              ovf_q;
  logic              full, can_pop, do_wr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign full    = (cnt_q == DEPTH_C);
  assign can_pop = pop_i && (cnt_q != '0);
  // A same-edge pop frees the oldest slot, so a full channel still accepts the write.
  assign do_wr   = wr_i && (!full || can_pop || OVW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (can_pop) vld_q[rd_ptr_q] <= 1'b0;
      if (do_wr) begin
        data_q[wr_ptr_q] <= wdata_i;
        vld_q[wr_ptr_q]  <= 1'b1;
        wr_ptr_q         <= nxt(wr_ptr_q);
      end
      if (can_pop || (do_wr && full)) rd_ptr_q <= nxt(rd_ptr_q);
      if (do_wr && !can_pop && !full)  cnt_q <= cnt_q + CW'(1);
      else if (can_pop && !do_wr)      cnt_q <= cnt_q - CW'(1);
      if (wr_i && full && !can_pop)    ovf_q <= 1'b1;
      else if (can_pop)                ovf_q <= 1'b0;
    end
  end

  for (genvar s = 0; s < DEPTH; s++) begin : g_slot
    assign slots_o[s*ENT_W +: ENT_W] = {data_q[s], vld_q[s]};
  end

  assign head_o = data_q[rd_ptr_q];
  assign cnt_o  = cnt_q;
  assign full_o = full;
  assign ovf_o  = ovf_q;
endmodule

module key_word_router #(
  parameter int NUM_CH    = 4,
  parameter int CH_BITS   = $clog2(NUM_CH),
  parameter int DATA_W    = 2,
  parameter int DEPTH     = 6,
  parameter int OVERWRITE = 1,
  parameter int TIMEOUT   = 1000,
  localparam int WORD_W   = CH_BITS + DATA_W,
  localparam int ENT_W    = DATA_W + 1,
  localparam int CW       = $clog2(DEPTH + 1),
  localparam int BCW      = $clog2(WORD_W + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          key1,
  input  logic                          key2,
  input  logic                          rd_en,
  input  logic [CH_BITS-1:0]            rd_ch,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic [NUM_CH*DEPTH*ENT_W-1:0] buf_o,
  output logic [NUM_CH*CW-1:0]          count_o,
  output logic [NUM_CH-1:0]             full_o,
  output logic [NUM_CH-1:0]             ovf_o,
  output logic [BCW-1:0]                bit_cnt_o,
  output logic                          word_done,
  output logic                          key_err,
  output logic                          timeout_o
);
  logic                          key1_q, key2_q;
  logic [WORD_W-2:0]             sr_q;
  logic [BCW-1:0]                bit_cnt_q;
  logic                          word_done_q, key_err_q, rd_valid_q;
  logic [DATA_W-1:0]             rd_data_q;
  logic                          rise1, rise2, both, acc, last, wr_fire, rd_ok, expire;
  logic [WORD_W-1:0]             word;
  logic [CH_BITS-1:0]            word_ch;
  logic [NUM_CH-1:0][DATA_W-1:0] head;
  logic [NUM_CH-1:0][CW-1:0]     cnt;

  assign rise1   = key1 & ~key1_q;
  assign rise2   = key2 & ~key2_q;
  assign both    = rise1 & rise2;
  assign acc     = rise1 ^ rise2;
  assign last    = (bit_cnt_q == BCW'(WORD_W - 1));
  assign word    = {sr_q, rise1};
  assign word_ch = word[WORD_W-1 -: CH_BITS];
  assign wr_fire = acc & last;
  assign rd_ok   = rd_en && (cnt[rd_ch] != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key1_q      <= 1'b0;
      key2_q      <= 1'b0;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      word_done_q <= 1'b0;
      key_err_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      key1_q      <= key1;
      key2_q      <= key2;
      key_err_q   <= both;
      word_done_q <= wr_fire;
      rd_valid_q  <= rd_ok;
      rd_data_q   <= rd_ok ? head[rd_ch] : '0;
      if (acc) begin
        if (last) begin
          sr_q      <= '0;
          bit_cnt_q <= '0;
        end else begin
          sr_q      <= word[WORD_W-2:0];
          bit_cnt_q <= bit_cnt_q + BCW'(1);
        end
      end else if (expire) begin
        sr_q      <= '0;
        bit_cnt_q <= '0;
      end
    end
  end

`ifdef KEY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q;
  logic          timeout_q;

  // An accepted bit on the expiry edge keeps the word alive.
  assign expire = (bit_cnt_q != '0) && !acc && (idle_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
      if (acc || expire || bit_cnt_q == '0) idle_q <= '0;
      else                                  idle_q <= idle_q + TW'(1);
    end
  end
  assign timeout_o = timeout_q;
`else
  assign expire    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    key_word_router_ch #(
      .DEPTH(DEPTH), .DATA_W(DATA_W), .OVERWRITE(OVERWRITE), .CW(CW)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .wr_i    (wr_fire && (word_ch == CH_BITS'(c))),
      .wdata_i (word[DATA_W-1:0]),
      .pop_i   (rd_en && (rd_ch == CH_BITS'(c))),
      .head_o  (head[c]),
      .cnt_o   (cnt[c]),
      .full_o  (full_o[c]),
      .ovf_o   (ovf_o[c]),
      .slots_o (buf_o[c*DEPTH*ENT_W +: DEPTH*ENT_W])
    );
  end

  assign count_o   = cnt;
  assign bit_cnt_o = bit_cnt_q;
  assign word_done = word_done_q;
  assign key_err   = key_err_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
endmodule

// File: tb/tb_key_word_router.sv
// Directed bench: one overwrite-policy and one drop-policy router driven by identical key/pop stimulus.

module tb_key_word_router;
  localparam int BW = 4*6*3;

  logic clk = 1'b0;
  logic rst, key1, key2, rd_en;
  logic [1:0] rd_ch;

  logic [1:0]    a_rd_data, b_rd_data;
  logic          a_rd_valid, b_rd_valid;
  logic [BW-1:0] a_buf, b_buf;
  logic [11:0]   a_cnt, b_cnt;
  logic [3:0]    a_full, b_full, a_ovf, b_ovf;
  logic [2:0]    a_bc, b_bc;
  logic          a_wd, b_wd, a_ke, b_ke, a_to, b_to;

  int npass = 0, nfail = 0, ntot = 0;

  always #5 clk = ~clk;

  key_word_router #(.OVERWRITE(1), .TIMEOUT(20)) u_a (
    .clk(clk), .rst(rst), .key1(key1), .key2(key2), .rd_en(rd_en), .rd_ch(rd_ch),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .buf_o(a_buf), .count_o(a_cnt),
    .full_o(a_full), .ovf_o(a_ovf), .bit_cnt_o(a_bc), .word_done(a_wd),
    .key_err(a_ke), .timeout_o(a_to));

  key_word_router #(.OVERWRITE(0), .TIMEOUT(20)) u_b (
    .clk(clk), .rst(rst), .key1(key1), .key2(key2), .rd_en(rd_en), .rd_ch(rd_ch),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .buf_o(b_buf), .count_o(b_cnt),
    .full_o(b_full), .ovf_o(b_ovf), .bit_cnt_o(b_bc), .word_done(b_wd),
    .key_err(b_ke), .timeout_o(b_to));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " a_buf"}, a_buf, 0);
    chk({tag, " b_buf"}, b_buf, 0);
    chk({tag, " a_cnt"}, a_cnt, 0);
    chk({tag, " b_cnt"}, b_cnt, 0);
    chk({tag, " a_flags"}, {a_full, a_ovf, a_bc}, 0);
    chk({tag, " b_flags"}, {b_full, b_ovf, b_bc}, 0);
    chk({tag, " a_pulses"}, {a_rd_valid, a_rd_data, a_wd, a_ke, a_to}, 0);
    chk({tag, " b_pulses"}, {b_rd_valid, b_rd_data, b_wd, b_ke, b_to}, 0);
  endtask

  // One key press: key asserted for one edge, released for the next.
  task automatic press(input bit b);
    @(negedge clk); key1 = b; key2 = !b;
    @(negedge clk); key1 = 1'b0; key2 = 1'b0;
  endtask

  task automatic send_word(input logic [1:0] ch, input logic [1:0] pl);
    press(ch[1]); press(ch[0]); press(pl[1]); press(pl[0]);
  endtask

  initial begin
    rst = 1'b1; key1 = 1'b0; key2 = 1'b0; rd_en = 1'b0; rd_ch = 2'd0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // 1011 -> ch2 payload 3
    press(1); press(0); press(1);
    chk("bitcnt3", a_bc, 3'd3);
    press(1);
    chk("wd_a", a_wd, 1'b1);
    chk("wd_b", b_wd, 1'b1);
    chk("bitcnt0", a_bc, 3'd0);
    chk("buf_ch2s0", a_buf, 72'(3'b111) << 36);
    chk("cnt_ch2", a_cnt, 12'h040);
    @(negedge clk);
    chk("wd_pulse", a_wd, 1'b0);

    // held key1 enters a single bit
    @(negedge clk); key1 = 1'b1;
    repeat (10) @(negedge clk);
    key1 = 1'b0;
    press(0);
    chk("held_bc", a_bc, 3'd2);

    // simultaneous rise
    @(negedge clk); key1 = 1'b1; key2 = 1'b1;
    @(negedge clk); key1 = 1'b0; key2 = 1'b0;
    chk("keyerr", {a_ke, b_ke}, 2'b11);
    chk("keyerr_bc", a_bc, 3'd2);
    @(negedge clk);
    chk("keyerr_pulse", a_ke, 1'b0);

    // complete 1010 -> ch2 payload 2 in slot1
    press(1); press(0);
    chk("buf_ch2s1", a_buf[41:39], 3'b101);
    chk("cnt_ch2_2", a_cnt[8:6], 3'd2);

    // pop empty ch3
    @(negedge clk); rd_en = 1'b1; rd_ch = 2'd3;
    @(negedge clk); rd_en = 1'b0;
    chk("pop_empty", {a_rd_valid, b_rd_valid}, 2'b00);
    chk("pop_empty_cnt", a_cnt, 12'h080);

    // pop ch2 -> 3
    @(negedge clk); rd_en = 1'b1; rd_ch = 2'd2;
    @(negedge clk); rd_en = 1'b0;
    chk("pop2_vld", a_rd_valid, 1'b1);
    chk("pop2_data", a_rd_data, 2'd3);
    chk("pop2_slot", a_buf[38:36], 3'b110);
    chk("pop2_cnt", a_cnt[8:6], 3'd1);
    @(negedge clk);
    chk("pop2_pulse", a_rd_valid, 1'b0);

    // ch0 fill: 0,1,2,3,0,1 then 2
    send_word(0, 0); send_word(0, 1); send_word(0, 2);
    send_word(0, 3); send_word(0, 0); send_word(0, 1);
    chk("ch0_full6", {a_full[0], a_ovf[0], b_full[0], b_ovf[0]}, 4'b1010);
    send_word(0, 2);
    chk("ow_cnt", a_cnt[2:0], 3'd6);
    chk("ow_full_ovf", {a_full[0], a_ovf[0]}, 2'b11);
    chk("ow_slot0", a_buf[2:0], 3'b101);
    chk("dr_cnt", b_cnt[2:0], 3'd6);
    chk("dr_ovf", b_ovf[0], 1'b1);
    chk("dr_slot0", b_buf[2:0], 3'b001);
    @(negedge clk); rd_en = 1'b1; rd_ch = 2'd0;
    @(negedge clk); rd_en = 1'b0;
    chk("ow_pop", {a_rd_valid, a_rd_data}, 3'b101);
    chk("dr_pop", {b_rd_valid, b_rd_data}, 3'b100);
    chk("pop_clr_ovf", {a_ovf, b_ovf}, 8'h00);
    chk("pop_cnt", {a_cnt[2:0], b_cnt[2:0]}, {3'd5, 3'd5});

    // ch1 full, pop on the completion edge of a 7th word
    send_word(1, 0); send_word(1, 1); send_word(1, 2);
    send_word(1, 3); send_word(1, 0); send_word(1, 1);
    chk("ch1_full", {a_full[1], b_full[1]}, 2'b11);
    press(0); press(1); press(1);
    @(negedge clk); key1 = 1'b1; rd_en = 1'b1; rd_ch = 2'd1;
    @(negedge clk); key1 = 1'b0; rd_en = 1'b0;
    chk("wp_rd", {a_rd_valid, a_rd_data, b_rd_valid, b_rd_data}, 6'b100100);
    chk("wp_wd", a_wd, 1'b1);
    chk("wp_cnt", {a_cnt[5:3], b_cnt[5:3]}, {3'd6, 3'd6});
    chk("wp_ovf", {a_ovf[1], b_ovf[1]}, 2'b00);
    chk("wp_slot", {a_buf[20:18], b_buf[20:18]}, 6'b111111);

    // asynchronous reset mid-word
    press(1);
    chk("mid_bc", a_bc, 3'd1);
    @(negedge clk); rst = 1'b1;
    #1;
    chk_zero("midreset");
    @(negedge clk); rst = 1'b0;

`ifdef KEY_TIMEOUT_EN
    press(1); press(0);
    repeat (19) @(negedge clk);
    chk("to_early", {a_to, a_bc}, {1'b0, 3'd2});
    @(negedge clk);
    chk("to_fire", {a_to, a_bc, b_to}, {1'b1, 3'd0, 1'b1});
    @(negedge clk);
    chk("to_pulse", a_to, 1'b0);
    send_word(3, 1);
    chk("to_word_cnt", a_cnt[11:9], 3'd1);
    chk("to_word_slot", a_buf[56:54], 3'b011);
`else
    press(1); press(0);
    repeat (25) @(negedge clk);
    chk("hold_partial", {a_to, a_bc}, {1'b0, 3'd2});
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
